// File: rtl/nn_fpga_top_if.sv
// Board-side pins of the digit classifier: Arduino header input and HEX0 seven-segment output.
interface nn_fpga_top_if;
    logic [15:0] ARDUINO_IO;
    logic [6:0]  HEX0;

    modport master (output ARDUINO_IO, input  HEX0);
    modport slave  (input  ARDUINO_IO, output HEX0);
endinterface

// File: rtl/nn_fpga_top.sv
// Board top of the FPGA digit classifier: serial frame capture into pixel RAM, inference, HEX0 display.
// Build option PRETRAINED_EN selects the real nn_core; otherwise an internal counting stub stands in.
module nn_fpga_top #(
    parameter int PIXELS      = 784,
    parameter int PIXEL_W     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic         CLOCK_50,
    input  logic [1:0]   KEY,
    nn_fpga_top_if.slave io
);
    localparam int AW = $clog2(PIXELS);
    localparam int BW = $clog2(PIXEL_W);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, INFER, SHOW} state_t;

    logic clk, rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY[1];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, sdata_s, rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], io.ARDUINO_IO[0]};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], io.ARDUINO_IO[1]};
            sclk_prev_q  <= sclk_s;
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]        px_cnt_q, px_cnt_d;
    logic [PIXEL_W-1:0]   shift_q, shift_d, shift_in;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 start_q, start_d;
    logic [6:0]           hex_q, hex_d;
    logic                 wr_en;
    logic                 done;
    logic [3:0]           digit;
    logic [9:0]           rd_addr;
    logic [PIXEL_W-1:0]   rd_data_q;
    logic [PIXEL_W-1:0]   pix_ram_q [PIXELS];

    assign shift_in = {sdata_s, shift_q[PIXEL_W-1:1]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        px_cnt_d  = px_cnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        start_d   = 1'b0;
        hex_d     = hex_q;
        wr_en     = 1'b0;
        case (state_q)
            // A rise out of IDLE or SHOW already carries frame bit 0.
            IDLE, SHOW: begin
                if (rise) begin
                    state_d   = RECV;
                    shift_d   = shift_in;
                    bit_cnt_d = BW'(1);
                    px_cnt_d  = '0;
                end
            end
            RECV: begin
                if (rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == BW'(PIXEL_W - 1)) begin
                        wr_en     = 1'b1;
                        bit_cnt_d = '0;
                        if (px_cnt_q == AW'(PIXELS - 1)) begin
                            px_cnt_d = '0;
                            state_d  = INFER;
                            start_d  = 1'b1;
                        end else begin
                            px_cnt_d = px_cnt_q + AW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    px_cnt_d  = '0;
                    shift_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            INFER: begin
                if (done) begin
                    state_d = SHOW;
                    hex_d   = seg7(digit);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            px_cnt_q  <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            start_q   <= 1'b0;
            hex_q     <= 7'h7F;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            px_cnt_q  <= px_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
            hex_q     <= hex_d;
        end
    end

    // Write and read phases never overlap, so one simple dual-port RAM suffices.
    always_ff @(posedge clk) begin
        if (wr_en)
            pix_ram_q[px_cnt_q] <= shift_in;
        rd_data_q <= pix_ram_q[rd_addr[AW-1:0]];
    end

    assign io.HEX0 = hex_q;

`ifdef PRETRAINED_EN
    nn_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_q),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data_q),
        .done_o    (done),
        .digit_o   (digit)
    );
`else
    // Stub: done four cycles after start, digit counts completed frames mod 10.
    logic       busy_q;
    logic [1:0] cnt_q;
    logic [3:0] frames_q;

    assign done    = busy_q && (cnt_q == 2'd3);
    assign digit   = (frames_q == 4'd9) ? 4'd0 : frames_q + 4'd1;
    assign rd_addr = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            frames_q <= '0;
        end else if (start_q) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (done) begin
                busy_q   <= 1'b0;
                frames_q <= digit;
            end else begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{KEY[0], io.ARDUINO_IO[15:2], rd_data_q, rd_addr};
endmodule

// File: tb/tb_nn_fpga_top.sv
// Bench for nn_fpga_top (stub build): frame capture, stub digit sequence, INFER edge rejection, timeout.
module tb_nn_fpga_top;
    localparam int NPX = 16;
    localparam int TMO = 300;
    localparam int HI  = 3;
    localparam int LO  = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic [1:0] key;
    nn_fpga_top_if bus();

    nn_fpga_top #(.PIXELS(NPX), .PIXEL_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .io       (bus.slave)
    );

    always #10 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [15:0] frame [NPX];
    int          frames_done = 0, starts = 0, exp_starts = 0;
    logic [6:0]  exp_now, exp_next;
    logic        pending = 1'b0, chk_en = 1'b0, done_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // HEX0 may only hold the current digit or move to the pending one, and must move the cycle after done.
    always @(negedge clk) begin
        if (chk_en) begin
            if (done_prev) chk("hex_after_done", bus.HEX0, exp_next);
            if (pending && bus.HEX0 === exp_next) begin
                exp_now = exp_next;
                pending = 1'b0;
            end else begin
                chk("hex_hold", bus.HEX0, exp_now);
            end
            done_prev = dut.done;
            if (dut.start_q) starts++;
        end
    end

    task automatic send_bit(input logic b);
        bus.ARDUINO_IO[1] = b;
        bus.ARDUINO_IO[0] = 1'b0;
        repeat (LO) @(negedge clk);
        bus.ARDUINO_IO[0] = 1'b1;
        repeat (HI) @(negedge clk);
    endtask

    task automatic send_frame();
        for (int k = 0; k < NPX; k++)
            for (int b = 0; b < 16; b++)
                send_bit(frame[k][b]);
        frames_done++;
        exp_next = SEG_TAB[frames_done % 10];
        pending  = 1'b1;
        exp_starts++;
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 60 && pending; i++) @(negedge clk);
        if (pending) chk("hex_update", bus.HEX0, exp_next);
        for (int k = 0; k < NPX; k++) chk("pix_ram", dut.pix_ram_q[k], frame[k]);
        chk("start_pulses", starts, exp_starts);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        key            = 2'b00;
        bus.ARDUINO_IO = '0;
        exp_now        = 7'h7F;
        exp_next       = 7'h7F;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.ARDUINO_IO[0] = ~bus.ARDUINO_IO[0];
            @(negedge clk);
        end
        chk("reset_hex", bus.HEX0, 7'h7F);
        chk("reset_px", dut.px_cnt_q, 0);
        chk("reset_bit", dut.bit_cnt_q, 0);
        key = 2'b11;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        // Partial frame, then a 20 ns reset with SCLK toggling.
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        chk("partial_bit", dut.bit_cnt_q, 4);
        chk("partial_px", dut.px_cnt_q, 1);
        key = 2'b01;
        #5 bus.ARDUINO_IO[0] = 1'b0;
        #5 bus.ARDUINO_IO[0] = 1'b1;
        #5 bus.ARDUINO_IO[0] = 1'b0;
        #5 key = 2'b11;
        @(negedge clk);
        chk("midreset_px", dut.px_cnt_q, 0);
        chk("midreset_bit", dut.bit_cnt_q, 0);
        chk("midreset_hex", bus.HEX0, 7'h7F);
        repeat (3) @(negedge clk);

        // Frame 1: framing pattern.
        for (int k = 0; k < NPX; k++) frame[k] = 16'(k * 16'h0123 + 16'h0055);
        frame[0]     = 16'h0A8B;
        frame[NPX-1] = 16'h0000;
        send_frame();
        finish_frame();
        chk("f1_ram0", dut.pix_ram_q[0], 16'h0A8B);
        chk("f1_ramlast", dut.pix_ram_q[NPX-1], 16'h0000);
        chk("f1_starts", starts, 1);
        chk("f1_hex", bus.HEX0, 7'h79);

        // Frame 2: stroke pixels, back to back from SHOW.
        for (int k = 0; k < NPX; k++)
            frame[k] = (k % 3 == 0) ? 16'h1FE0 : (k % 3 == 1) ? 16'h18D9 : 16'h0000;
        send_frame();
        finish_frame();
        chk("f2_hex", bus.HEX0, 7'h24);

        // Frame 3, followed by an SCLK rise that lands while inference runs.
        for (int k = 0; k < NPX; k++) frame[k] = 16'($urandom);
        send_frame();
        bus.ARDUINO_IO[0] = 1'b0;
        @(negedge clk);
        bus.ARDUINO_IO[0] = 1'b1;
        @(negedge clk);
        bus.ARDUINO_IO[0] = 1'b0;
        finish_frame();
        chk("infer_px", dut.px_cnt_q, 0);
        chk("infer_bit", dut.bit_cnt_q, 0);
        chk("f3_hex", bus.HEX0, 7'h30);

        // Frame 4 received intact from SHOW.
        for (int k = 0; k < NPX; k++) frame[k] = 16'($urandom);
        send_frame();
        finish_frame();
        chk("f4_hex", bus.HEX0, 7'h19);

        // Timeout: 100 bits, SCLK stalls, then a full frame.
        for (int k = 0; k < NPX; k++) frame[k] = 16'($urandom);
        for (int i = 0; i < 100; i++) send_bit(frame[i / 16][i % 16]);
        chk("pre_tmo_px", dut.px_cnt_q, 6);
        chk("pre_tmo_bit", dut.bit_cnt_q, 4);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_px", dut.px_cnt_q, 0);
        chk("tmo_bit", dut.bit_cnt_q, 0);
        chk("tmo_starts", starts, 4);
        for (int k = 0; k < NPX; k++) frame[k] = 16'($urandom) ^ 16'h5A5A;
        send_frame();
        finish_frame();
        chk("f5_starts", starts, 5);
        chk("f5_hex", bus.HEX0, 7'h12);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
